// File: rtl/coverfloat_pkg.sv
// Shared types and layout constants for the coverfloat vector driver.
// Word indices describe the order in which a vector arrives on the 32-bit input stream.
package coverfloat_pkg;

    localparam int unsigned COVERFLOAT_VEC_WORDS = 21;
    localparam int unsigned IDX_W                = 5;

    localparam int unsigned IDX_OP   = 0;
    localparam int unsigned IDX_RM   = 1;
    localparam int unsigned IDX_EN   = 2;
    localparam int unsigned IDX_A0   = 3;
    localparam int unsigned IDX_B0   = 7;
    localparam int unsigned IDX_C0   = 11;
    localparam int unsigned IDX_RES0 = 15;
    localparam int unsigned IDX_FMT  = 19;
    localparam int unsigned IDX_EXC  = 20;

    // Bit positions of the 3-bit format codes inside the fmt word.
    localparam int unsigned FMT_A_LSB   = 0;
    localparam int unsigned FMT_B_LSB   = 3;
    localparam int unsigned FMT_C_LSB   = 6;
    localparam int unsigned FMT_RES_LSB = 9;

    typedef enum logic [2:0] {
        FMT_HALF   = 3'b000,
        FMT_FLOAT  = 3'b001,
        FMT_DOUBLE = 3'b010,
        FMT_QUAD   = 3'b011,
        FMT_INT    = 3'b100,
        FMT_LONG   = 3'b101
    } fmt_e;

    typedef enum logic [0:0] {
        StCollect = 1'b0,
        StEmit    = 1'b1
    } drv_state_e;

    typedef struct packed {
        logic [31:0]  op;
        logic [31:0]  rm;
        logic [31:0]  enable;
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] c;
        logic [127:0] result;
        logic [2:0]   a_fmt;
        logic [2:0]   b_fmt;
        logic [2:0]   c_fmt;
        logic [2:0]   res_fmt;
        logic [31:0]  exc;
    } vec_t;

    function automatic logic fmt_code_invalid(input logic [2:0] code);
        return code > FMT_LONG;
    endfunction

endpackage

// File: rtl/coverfloat_vector_driver.sv
// Assembles 21-word stimulus vectors and presents each one with a single-cycle valid pulse.
// Optional: define COVERFLOAT_FMT_CHECK_EN to drop vectors carrying reserved fmt codes.
module coverfloat_vector_driver
    import coverfloat_pkg::*;
#(
    parameter int unsigned WORDS_PER_VEC = COVERFLOAT_VEC_WORDS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [31:0]  in_data,
    output logic         in_ready,
    input  logic         abort,
    output logic         valid,
    output logic [31:0]  op,
    output logic [31:0]  rm,
    output logic [31:0]  enableBits,
    output logic [127:0] a,
    output logic [127:0] b,
    output logic [127:0] c,
    output logic [127:0] result,
    output logic [2:0]   aFmt,
    output logic [2:0]   bFmt,
    output logic [2:0]   cFmt,
    output logic [2:0]   resultFmt,
    output logic [31:0]  exceptionBits,
    output logic [31:0]  vec_count,
    output logic         fmt_err
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(WORDS_PER_VEC - 1);

    drv_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      stage_q [COVERFLOAT_VEC_WORDS];
    logic [31:0]      stage_d [COVERFLOAT_VEC_WORDS];
    vec_t             out_q, out_d, staged_vec;
    logic             valid_q, valid_d;
    logic [31:0]      vec_count_q, vec_count_d;
    logic             accept, last_word, load, fmt_bad;

    assign accept    = in_valid && in_ready;
    assign last_word = (idx_q == LastIdx);
    // Final word handshake: outputs load on this edge so they are stable during the EMIT cycle.
    assign load      = accept && last_word;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StCollect;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StCollect: if (load) state_d = StEmit;
            StEmit:    state_d = StCollect;
            default:   state_d = StCollect;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        if (state_q == StCollect && !abort) begin
            in_ready = 1'b1;
        end
    end

    // ---------------- Staging ----------------
    always_comb begin
        stage_d = stage_q;
        idx_d   = idx_q;
        if (state_q == StCollect && abort) begin
            idx_d = '0;
            for (int unsigned i = 0; i < COVERFLOAT_VEC_WORDS; i++) begin
                stage_d[i] = '0;
            end
        end else if (accept) begin
            stage_d[idx_q] = in_data;
            idx_d          = last_word ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Exception word is taken straight from the bus: it is the word being accepted on load.
    always_comb begin
        staged_vec.op      = stage_q[IDX_OP];
        staged_vec.rm      = stage_q[IDX_RM];
        staged_vec.enable  = stage_q[IDX_EN];
        staged_vec.a       = {stage_q[IDX_A0+3], stage_q[IDX_A0+2],
                              stage_q[IDX_A0+1], stage_q[IDX_A0]};
        staged_vec.b       = {stage_q[IDX_B0+3], stage_q[IDX_B0+2],
                              stage_q[IDX_B0+1], stage_q[IDX_B0]};
        staged_vec.c       = {stage_q[IDX_C0+3], stage_q[IDX_C0+2],
                              stage_q[IDX_C0+1], stage_q[IDX_C0]};
        staged_vec.result  = {stage_q[IDX_RES0+3], stage_q[IDX_RES0+2],
                              stage_q[IDX_RES0+1], stage_q[IDX_RES0]};
        staged_vec.a_fmt   = stage_q[IDX_FMT][FMT_A_LSB +: 3];
        staged_vec.b_fmt   = stage_q[IDX_FMT][FMT_B_LSB +: 3];
        staged_vec.c_fmt   = stage_q[IDX_FMT][FMT_C_LSB +: 3];
        staged_vec.res_fmt = stage_q[IDX_FMT][FMT_RES_LSB +: 3];
        staged_vec.exc     = in_data;
    end

    logic [51:0] unused_stage;
    assign unused_stage = {stage_q[IDX_EXC], stage_q[IDX_FMT][31:12]};

`ifdef COVERFLOAT_FMT_CHECK_EN
    logic fmt_err_q;

    assign fmt_bad = fmt_code_invalid(staged_vec.a_fmt) | fmt_code_invalid(staged_vec.b_fmt) |
                     fmt_code_invalid(staged_vec.c_fmt) | fmt_code_invalid(staged_vec.res_fmt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fmt_err_q <= 1'b0;
        end else begin
            fmt_err_q <= load && fmt_bad;
        end
    end

    assign fmt_err = fmt_err_q;
`else
    assign fmt_bad = 1'b0;
    assign fmt_err = 1'b0;
`endif

    // ---------------- Output fields ----------------
    always_comb begin
        out_d       = out_q;
        valid_d     = 1'b0;
        vec_count_d = vec_count_q;
        if (load && !fmt_bad) begin
            out_d       = staged_vec;
            valid_d     = 1'b1;
            vec_count_d = vec_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q       <= '0;
            out_q       <= '0;
            valid_q     <= 1'b0;
            vec_count_q <= '0;
            for (int unsigned i = 0; i < COVERFLOAT_VEC_WORDS; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            idx_q       <= idx_d;
            out_q       <= out_d;
            valid_q     <= valid_d;
            vec_count_q <= vec_count_d;
            stage_q     <= stage_d;
        end
    end

    assign valid         = valid_q;
    assign op            = out_q.op;
    assign rm            = out_q.rm;
    assign enableBits    = out_q.enable;
    assign a             = out_q.a;
    assign b             = out_q.b;
    assign c             = out_q.c;
    assign result        = out_q.result;
    assign aFmt          = out_q.a_fmt;
    assign bFmt          = out_q.b_fmt;
    assign cFmt          = out_q.c_fmt;
    assign resultFmt     = out_q.res_fmt;
    assign exceptionBits = out_q.exc;
    assign vec_count     = vec_count_q;

endmodule

// File: tb/tb_coverfloat_vector_driver.sv
// Randomized bench for coverfloat_vector_driver against a word-queue reference model.
// Expectations for dropped vectors follow COVERFLOAT_FMT_CHECK_EN when it is defined.
module tb_coverfloat_vector_driver;

    typedef logic [31:0] vec_words_t [21];

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [31:0]  in_data;
    logic         in_ready;
    logic         abort;
    logic         valid;
    logic [31:0]  op, rm, enableBits, exceptionBits, vec_count;
    logic [127:0] a, b, c, result;
    logic [2:0]   aFmt, bFmt, cFmt, resultFmt;
    logic         fmt_err;

    always #5 clk = ~clk;

    coverfloat_vector_driver dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .abort         (abort),
        .valid         (valid),
        .op            (op),
        .rm            (rm),
        .enableBits    (enableBits),
        .a             (a),
        .b             (b),
        .c             (c),
        .result        (result),
        .aFmt          (aFmt),
        .bFmt          (bFmt),
        .cFmt          (cFmt),
        .resultFmt     (resultFmt),
        .exceptionBits (exceptionBits),
        .vec_count     (vec_count),
        .fmt_err       (fmt_err)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // ---------------- Reference model ----------------
    logic [31:0]  m_words[$];
    bit           m_emit;
    bit           hs;
    logic [31:0]  e_op, e_rm, e_en, e_exc, e_cnt;
    logic [127:0] e_a, e_b, e_c, e_res;
    logic [11:0]  e_fmt;
    bit           e_valid, e_err;

    function automatic logic [127:0] wide(input int unsigned base);
        logic [127:0] v = '0;
        for (int k = 0; k < 4; k++) v = v | (128'(m_words[base + k]) << (32 * k));
        return v;
    endfunction

    function automatic bit fmt_ok(input logic [31:0] w);
        for (int k = 0; k < 4; k++) if (((w >> (3 * k)) & 32'd7) >= 32'd6) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_words.delete();
        m_emit = 0;
        e_op = '0; e_rm = '0; e_en = '0; e_exc = '0; e_cnt = '0;
        e_a = '0; e_b = '0; e_c = '0; e_res = '0; e_fmt = '0;
        e_valid = 0; e_err = 0;
    endtask

    task automatic model_finish_vector();
        bit drop = 0;
`ifdef COVERFLOAT_FMT_CHECK_EN
        drop = !fmt_ok(m_words[19]);
`endif
        if (drop) begin
            e_err = 1;
        end else begin
            e_valid = 1;
            e_cnt   = e_cnt + 1;
            e_op = m_words[0]; e_rm = m_words[1]; e_en = m_words[2];
            e_a = wide(3); e_b = wide(7); e_c = wide(11); e_res = wide(15);
            e_fmt = 12'(m_words[19] & 32'hfff);
            e_exc = m_words[20];
        end
    endtask

    task automatic check_outputs();
        check("valid", valid, e_valid);
        check("fmt_err", fmt_err, e_err);
        check("vec_count", vec_count, e_cnt);
        check("op", op, e_op);
        check("rm", rm, e_rm);
        check("enableBits", enableBits, e_en);
        check("a", a, e_a);
        check("b", b, e_b);
        check("c", c, e_c);
        check("result", result, e_res);
        check("fmts", {resultFmt, cFmt, bFmt, aFmt}, e_fmt);
        check("exceptionBits", exceptionBits, e_exc);
    endtask

    // One clock cycle: drive at negedge, compare outputs at the following negedge.
    task automatic step(input bit v, input logic [31:0] d, input bit ab);
        bit exp_ready;
        in_valid = v; in_data = d; abort = ab;
        #1;
        exp_ready = !m_emit && !ab;
        check("in_ready", in_ready, exp_ready);
        hs = v && exp_ready;
        @(posedge clk);
        e_valid = 0; e_err = 0;
        if (m_emit) begin
            m_emit = 0;
        end else if (ab) begin
            m_words.delete();
        end else if (hs) begin
            m_words.push_back(d);
            if (m_words.size() == 21) begin
                model_finish_vector();
                m_words.delete();
                m_emit = 1;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_data = $urandom; abort = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1; in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_ready", in_ready, 1'b1);
        check_outputs();
    endtask

    // mode 0: continuous valid, 1: toggling, 2: random gaps. Sends the first nwords words.
    task automatic send_vec(input vec_words_t w, input int mode, input int nwords);
        bit ph = 1;
        for (int i = 0; i < nwords; i++) begin
            int tries = 0;
            do begin
                bit v;
                v = (mode == 0) ? 1'b1 : (mode == 1) ? ph : ($urandom_range(0, 2) != 0);
                ph = !ph;
                step(v, w[i], 1'b0);
                tries++;
            end while (!hs && tries < 100);
            if (!hs) begin
                check("handshake_timeout", 128'(tries), 128'd0);
                return;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom, 1'b0);
    endtask

    function automatic vec_words_t make_vec(input logic [31:0] opw, input logic [31:0] fmtw);
        vec_words_t w;
        for (int i = 0; i < 21; i++) w[i] = $urandom;
        w[0]  = opw;
        w[19] = fmtw;
        return w;
    endfunction

    initial begin
        vec_words_t w;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; abort = 1'b0;
        @(negedge clk);
        do_reset();

        // Directed vector, continuous valid.
        w = make_vec(32'h10, 32'h249);
        w[1] = 32'h2; w[3] = 0; w[4] = 0; w[5] = 0; w[6] = 32'h3FF0_0000;
        send_vec(w, 0, 21);
        idle(2);
        check("fmt_float", {resultFmt, cFmt, bFmt, aFmt}, 12'h249);
        check("count1", vec_count, 32'd1);

        // Same vector with toggling valid.
        send_vec(w, 1, 21);
        idle(2);

        // Abort after word 9, then a fresh vector.
        send_vec(make_vec(32'h33, 32'h249), 0, 10);
        step(1'b1, $urandom, 1'b1);
        send_vec(make_vec(32'h22, 32'h249), 2, 21);
        idle(2);
        check("op_after_abort", op, 32'h22);

        // Abort raised in the EMIT cycle is ignored.
        send_vec(make_vec(32'h44, 32'h000), 0, 21);
        step(1'b1, $urandom, 1'b1);
        idle(1);

        // Three back-to-back vectors from reset.
        do_reset();
        for (int k = 0; k < 3; k++) send_vec(make_vec($urandom, 32'h0DB), 0, 21);
        idle(2);
        check("count3", vec_count, 32'd3);

        // Reserved fmt codes.
        send_vec(make_vec(32'h55, 32'h007), 0, 21);
        idle(2);

        // Reset mid-vector, then a clean vector.
        send_vec(make_vec(32'h66, 32'h249), 0, 15);
        do_reset();
        send_vec(make_vec(32'h77, 32'h123), 0, 21);
        idle(2);
        check("count_after_rst", vec_count, 32'd1);

        // Random traffic.
        for (int k = 0; k < 30; k++) begin
            logic [31:0] f;
            int mode;
            f = ($urandom_range(0, 3) == 0) ? $urandom : 32'(($urandom & 32'hfff) & 32'h96d);
            mode = $urandom_range(0, 2);
            if ($urandom_range(0, 4) == 0) begin
                send_vec(make_vec($urandom, f), mode, $urandom_range(0, 20));
                step($urandom_range(0, 1) == 1, $urandom, 1'b1);
            end
            send_vec(make_vec($urandom, f), mode, 21);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got %0d checks, expected completion", n_checks);
        $fatal(1);
    end

endmodule
